bcd_press_counter: RTL



---
 rtl/bcd_counter_pkg.sv | 14 +
 rtl/switch_debounce.sv | 93 +++++++++
 rtl/bcd_press_counter.sv | 74 +++++++
 3 files changed

// File: rtl/bcd_counter_pkg.sv
// rtl/bcd_counter_pkg.sv - shared debounce state encoding and BCD digit constants
package bcd_counter_pkg;

   typedef enum logic [1:0] {
      S_STABLE_LOW  = 2'd0,
      S_CHECK_HIGH  = 2'd1,
      S_STABLE_HIGH = 2'd2,
      S_CHECK_LOW   = 2'd3
   } deb_state_e;

   localparam int                     DIGIT_WIDTH   = 4;
   localparam logic [DIGIT_WIDTH-1:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - two-flop synchronizer plus debounce FSM
// Emits a registered debounced level and a one-cycle pulse per accepted release.
module switch_debounce
   import bcd_counter_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic switch_in,
   output logic debounced,
   output logic release_pulse
);

   localparam int            CW    = $clog2(DEBOUNCE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_LIMIT);
   localparam logic [CW-1:0] ONE   = CW'(1);

   logic          sync1_q, sync1_d, sync2_q, sync2_d;
   deb_state_e    state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          debounced_q, debounced_d;
   logic          pulse_q, pulse_d;

   always_comb begin
      sync1_d = switch_in;
      sync2_d = sync1_q;
      state_d = state_q;
      count_d = count_q;
      pulse_d = 1'b0;
      case (state_q)
         S_STABLE_LOW: begin
            count_d = sync2_q ? ONE : '0;
            if (sync2_q) state_d = S_CHECK_HIGH;
         end
         S_CHECK_HIGH: begin
            if (!sync2_q) begin
               state_d = S_STABLE_LOW;
               count_d = '0;
            end else if (count_q == LIMIT) begin
               state_d = S_STABLE_HIGH;
               count_d = '0;
            end else begin
               count_d = count_q + ONE;
            end
         end
         S_STABLE_HIGH: begin
            count_d = sync2_q ? '0 : ONE;
            if (!sync2_q) state_d = S_CHECK_LOW;
         end
         S_CHECK_LOW: begin
            if (sync2_q) begin
               state_d = S_STABLE_HIGH;
               count_d = '0;
            end else if (count_q == LIMIT) begin
               state_d = S_STABLE_LOW;
               count_d = '0;
               pulse_d = 1'b1;
            end else begin
               count_d = count_q + ONE;
            end
         end
         default: begin
            state_d = S_STABLE_LOW;
            count_d = '0;
         end
      endcase
      // Level follows the next state so it changes on the same edge as the FSM.
      debounced_d = (state_d == S_STABLE_HIGH) || (state_d == S_CHECK_LOW);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         state_q     <= S_STABLE_LOW;
         count_q     <= '0;
         debounced_q <= 1'b0;
         pulse_q     <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         state_q     <= state_d;
         count_q     <= count_d;
         debounced_q <= debounced_d;
         pulse_q     <= pulse_d;
      end
   end

   assign debounced     = debounced_q;
   assign release_pulse = pulse_q;

endmodule

// File: rtl/bcd_press_counter.sv
// rtl/bcd_press_counter.sv - debounced push-button driving a two-digit BCD counter
// Counts completed presses 00..99 with a wrap pulse on the 99 -> 00 rollover.
module bcd_press_counter
   import bcd_counter_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT = 250000
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst_L,
   input  logic                   i_Switch,
   input  logic                   i_Clear,
   output logic [DIGIT_WIDTH-1:0] o_Ones,
   output logic [DIGIT_WIDTH-1:0] o_Tens,
   output logic                   o_Switch_Debounced,
   output logic                   o_Press_Pulse,
   output logic                   o_Wrap
);

   localparam logic [DIGIT_WIDTH-1:0] DIGIT_ONE = DIGIT_WIDTH'(1);

   logic                   press_pulse;
   logic [DIGIT_WIDTH-1:0] ones_q, ones_d, tens_q, tens_d;
   logic                   wrap_q, wrap_d;

   switch_debounce #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
   ) u_debounce (
      .clk          (i_Clk),
      .rst_n        (i_Rst_L),
      .switch_in    (i_Switch),
      .debounced    (o_Switch_Debounced),
      .release_pulse(press_pulse)
   );

   // Clear wins over a coincident press; that press is dropped.
   always_comb begin
      ones_d = ones_q;
      tens_d = tens_q;
      wrap_d = 1'b0;
      if (i_Clear) begin
         ones_d = '0;
         tens_d = '0;
      end else if (press_pulse) begin
         if (ones_q < BCD_MAX_DIGIT) begin
            ones_d = ones_q + DIGIT_ONE;
         end else if (tens_q < BCD_MAX_DIGIT) begin
            ones_d = '0;
            tens_d = tens_q + DIGIT_ONE;
         end else begin
            ones_d = '0;
            tens_d = '0;
            wrap_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         ones_q <= '0;
         tens_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         ones_q <= ones_d;
         tens_q <= tens_d;
         wrap_q <= wrap_d;
      end
   end

   assign o_Ones        = ones_q;
   assign o_Tens        = tens_q;
   assign o_Wrap        = wrap_q;
   assign o_Press_Pulse = press_pulse;

endmodule
